// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, command bytes, defaults.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_ST    = 3'd1,
        RUN_ST     = 3'd2,
        STEP_WAIT  = 3'd3,
        STEP_PULSE = 3'd4,
        DONE       = 3'd5
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_EXIT = 8'h58;

    localparam int unsigned DEFAULT_INSTR_W   = 32;
    localparam int unsigned DEFAULT_PC_W      = 32;
    localparam int unsigned DEFAULT_MEM_DEPTH = 64;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Command/program byte input, pipeline handshake and memory-write bus of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
) ();

    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               halt_detected;
    logic               mips_enable;
    logic               pc_enable;
    logic               wr_memory_instruction_enable;
    logic [INSTR_W-1:0] instruction_to_write;
    logic [PC_W-1:0]    address_to_write;
    logic               program_loaded;
    logic               load_error;
    logic [31:0]        cycle_count;
    logic [2:0]         state;

    // Host / pipeline side: supplies bytes and halt, observes everything else.
    modport master (
        output rx_data, rx_valid, halt_detected,
        input  mips_enable, pc_enable, wr_memory_instruction_enable,
               instruction_to_write, address_to_write, program_loaded,
               load_error, cycle_count, state
    );

    // Sequencer side.
    modport slave (
        input  rx_data, rx_valid, halt_detected,
        output mips_enable, pc_enable, wr_memory_instruction_enable,
               instruction_to_write, address_to_write, program_loaded,
               load_error, cycle_count, state
    );

endinterface

// File: rtl/fetch_sequencer_byte_word_assembler.sv
// Packs a byte stream big-endian into words; pulses word_valid the cycle after the last byte.
module byte_word_assembler #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [WORD_W-1:0] shift_q;
    logic [1:0]        byte_cnt;

    // Shift bytes in; on the 4th byte latch the full word and raise a one-cycle valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                shift_q  <= '0;
                byte_cnt <= '0;
            end else if (byte_valid) begin
                shift_q  <= {shift_q[WORD_W-9:0], byte_in};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= {shift_q[WORD_W-9:0], byte_in};
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loads instruction memory from a byte stream, then runs or single-steps
// the pipeline via mips_enable/pc_enable until halt.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned        INSTR_W   = DEFAULT_INSTR_W,
    parameter int unsigned        PC_W      = DEFAULT_PC_W,
    parameter int unsigned        MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic            clk,
    input  logic            reset,
    fetch_sequencer_if.slave bus
);

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'((MEM_DEPTH - 1) * 4);

    state_t             fsm_state;
    logic               mips_enable_q;
    logic [PC_W-1:0]    address_q;
    logic [31:0]        cycle_count_q;
    logic               program_loaded_q;
    logic               load_error_q;

    logic               asm_clear;
    logic               asm_byte_valid;
    logic [INSTR_W-1:0] asm_word;
    logic               asm_word_valid;

    // Bytes feed the assembler only while loading; a LOAD command restarts it.
    always_comb begin
        asm_clear      = bus.rx_valid && (bus.rx_data == CMD_LOAD) &&
                         ((fsm_state == IDLE) || (fsm_state == DONE));
        asm_byte_valid = bus.rx_valid && (fsm_state == LOAD_ST);
    end

    byte_word_assembler #(
        .WORD_W (INSTR_W)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_byte_valid),
        .byte_in    (bus.rx_data),
        .word       (asm_word),
        .word_valid (asm_word_valid)
    );

    // Control FSM with address/cycle counters; enables are set on the edge entering an active state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_state        <= IDLE;
            mips_enable_q    <= 1'b0;
            address_q        <= '0;
            cycle_count_q    <= '0;
            program_loaded_q <= 1'b0;
            load_error_q     <= 1'b0;
        end else begin
            if (mips_enable_q) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
            case (fsm_state)
                IDLE, DONE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data == CMD_LOAD) begin
                            fsm_state        <= LOAD_ST;
                            address_q        <= '0;
                            program_loaded_q <= 1'b0;
                            load_error_q     <= 1'b0;
                        end else if ((bus.rx_data == CMD_RUN) && program_loaded_q) begin
                            fsm_state     <= RUN_ST;
                            mips_enable_q <= 1'b1;
                            cycle_count_q <= '0;
                        end else if ((bus.rx_data == CMD_STEP) && program_loaded_q) begin
                            fsm_state     <= STEP_WAIT;
                            cycle_count_q <= '0;
                        end
                    end
                end
                LOAD_ST: begin
                    // The write strobe is the assembler's registered pulse, so the
                    // address advances at the end of the strobe cycle.
                    if (asm_word_valid) begin
                        address_q <= address_q + PC_W'(4);
                        if (asm_word == HALT_WORD) begin
                            fsm_state        <= IDLE;
                            program_loaded_q <= 1'b1;
                        end else if (address_q == LAST_ADDR) begin
                            fsm_state        <= IDLE;
                            load_error_q     <= 1'b1;
                            program_loaded_q <= 1'b0;
                        end
                    end
                end
                RUN_ST: begin
                    if (bus.halt_detected) begin
                        fsm_state     <= DONE;
                        mips_enable_q <= 1'b0;
                    end
                end
                STEP_WAIT: begin
                    if (bus.halt_detected) begin
                        fsm_state <= DONE;
                    end else if (bus.rx_valid && (bus.rx_data == CMD_NEXT)) begin
                        fsm_state     <= STEP_PULSE;
                        mips_enable_q <= 1'b1;
                    end else if (bus.rx_valid && (bus.rx_data == CMD_EXIT)) begin
                        fsm_state <= DONE;
                    end
                end
                STEP_PULSE: begin
                    mips_enable_q <= 1'b0;
                    fsm_state     <= bus.halt_detected ? DONE : STEP_WAIT;
                end
                default: begin
                    fsm_state     <= IDLE;
                    mips_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mips_enable                  = mips_enable_q;
    assign bus.pc_enable                    = mips_enable_q;
    assign bus.wr_memory_instruction_enable = asm_word_valid;
    assign bus.instruction_to_write         = asm_word;
    assign bus.address_to_write             = address_q;
    assign bus.program_loaded               = program_loaded_q;
    assign bus.load_error                   = load_error_q;
    assign bus.cycle_count                  = cycle_count_q;
    assign bus.state                        = fsm_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random programs, run and step sessions.
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } wr_t;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;
    int en_cycles = 0;

    wr_t         exp_q[$];
    logic [31:0] prog[$];

    // Reference model state
    bit          model_loaded = 1'b0;
    logic [31:0] model_count  = '0;
    state_t      model_state  = IDLE;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.INSTR_W(32), .PC_W(32)) bus ();

    fetch_sequencer #(
        .INSTR_W   (32),
        .PC_W      (32),
        .MEM_DEPTH (DEPTH),
        .HALT_WORD (HALT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and counts enabled cycles.
    always @(negedge clk) begin
        if (bus.mips_enable === 1'b1) begin
            en_cycles++;
            check("pc_enable_follows", 64'(bus.pc_enable), 64'd1);
            check("no_write_while_running", 64'(bus.wr_memory_instruction_enable), 64'd0);
        end
        if (bus.wr_memory_instruction_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got word %0h at %0h expected no write",
                         bus.instruction_to_write, bus.address_to_write);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_word", 64'(bus.instruction_to_write), 64'(e.word));
                check("wr_addr", 64'(bus.address_to_write), 64'(e.addr));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; one-cycle strobe then gap idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mips_enable"}, 64'(bus.mips_enable), 64'd0);
        check({tag, "_pc_enable"}, 64'(bus.pc_enable), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.wr_memory_instruction_enable), 64'd0);
        check({tag, "_instr"}, 64'(bus.instruction_to_write), 64'd0);
        check({tag, "_addr"}, 64'(bus.address_to_write), 64'd0);
        check({tag, "_loaded"}, 64'(bus.program_loaded), 64'd0);
        check({tag, "_error"}, 64'(bus.load_error), 64'd0);
        check({tag, "_cycle_count"}, 64'(bus.cycle_count), 64'd0);
        check({tag, "_state"}, 64'(bus.state), 64'(IDLE));
    endtask

    task automatic gen_prog(input bit want_halt);
        int nw;
        logic [31:0] w;
        prog.delete();
        nw = want_halt ? int'($urandom_range(1, DEPTH)) : int'($urandom_range(DEPTH, DEPTH + 2));
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            prog.push_back(w);
        end
        if (want_halt) prog[nw-1] = HALT;
    endtask

    // Load prog: model decides which words get written and how the load ends.
    task automatic do_load();
        bit loaded = 1'b0;
        bit err    = 1'b0;
        int n      = 0;
        logic [31:0] w;
        for (int i = 0; i < prog.size(); i++) begin
            exp_q.push_back('{word: prog[i], addr: 32'(i * 4)});
            n = i + 1;
            if (prog[i] == HALT) begin
                loaded = 1'b1;
                break;
            end
            if (i == int'(DEPTH) - 1) begin
                err = 1'b1;
                break;
            end
        end
        send_byte(CMD_LOAD, $urandom_range(0, 2));
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[31:24], $urandom_range(0, 2));
                w = w << 8;
            end
        end
        idle(3);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check("program_loaded", 64'(bus.program_loaded), 64'(loaded));
        check("load_error", 64'(bus.load_error), 64'(err));
        check("state_after_load", 64'(bus.state), 64'(IDLE));
        model_loaded = loaded;
        model_state  = IDLE;
    endtask

    // RUN, then halt sampled on the n-th enabled cycle.
    task automatic do_run(input int n);
        int base;
        base = en_cycles;
        send_byte(CMD_RUN, 0);
        if (model_loaded) begin
            repeat (n - 1) @(negedge clk);
            bus.halt_detected = 1'b1;
            @(negedge clk);
            bus.halt_detected = 1'b0;
            idle(2);
            model_count = 32'(n);
            model_state = DONE;
        end else begin
            idle(n + 2);
        end
        check("run_enable_cycles", 64'(en_cycles - base), model_loaded ? 64'(n) : 64'd0);
        check("run_cycle_count", 64'(bus.cycle_count), 64'(model_count));
        check("run_state", 64'(bus.state), 64'(model_state));
    endtask

    // STEP, k NEXTs, then EXIT or (NEXT together with halt).
    task automatic do_step(input int k, input bit halt_with_next);
        int base;
        base = en_cycles;
        send_byte(CMD_STEP, 1);
        for (int j = 0; j < k; j++) send_byte(CMD_NEXT, $urandom_range(1, 3));
        if (halt_with_next) begin
            bus.rx_data       = CMD_NEXT;
            bus.rx_valid      = 1'b1;
            bus.halt_detected = 1'b1;
            @(negedge clk);
            bus.rx_valid      = 1'b0;
            bus.halt_detected = 1'b0;
        end else begin
            send_byte(CMD_EXIT, 1);
        end
        idle(2);
        if (model_loaded) begin
            model_count = 32'(k);
            model_state = DONE;
        end
        check("step_enable_cycles", 64'(en_cycles - base), model_loaded ? 64'(k) : 64'd0);
        check("step_cycle_count", 64'(bus.cycle_count), 64'(model_count));
        check("step_state", 64'(bus.state), 64'(model_state));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.halt_detected = 1'b0;
        idle(2);
        check_all_zero("reset");
        reset = 1'b0;
        idle(1);

        // RUN without a program is ignored
        do_run(5);

        // Asynchronous reset in the middle of a load
        send_byte(CMD_LOAD, 0);
        send_byte(8'h12, 1);
        send_byte(8'h34, 0);
        #2 reset = 1'b1;
        #1 check_all_zero("midload_reset");
        @(negedge clk);
        reset = 1'b0;
        model_loaded = 1'b0;
        model_count  = '0;
        model_state  = IDLE;
        idle(1);

        // Directed two-word program
        prog.delete();
        prog.push_back(32'h2008_0005);
        prog.push_back(HALT);
        do_load();
        do_run(10);
        do_step(3, 1'b0);
        do_step(0, 1'b1);
        do_step(2, 1'b1);

        // Directed overflow: DEPTH non-halt words
        gen_prog(1'b0);
        do_load();
        do_run(4);
        do_step(2, 1'b0);

        // Random sessions
        for (int it = 0; it < 8; it++) begin
            gen_prog(1'($urandom_range(0, 3) != 0));
            do_load();
            do_run($urandom_range(1, 20));
            do_step($urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
